// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the decode register file and its operand scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned ZERO_REG     = 0;
  localparam int unsigned SB_TAG_WIDTH = 4;

  // Scoreboard entry layout at the default tag width.
  typedef struct packed {
    logic                    busy;
    logic [SB_TAG_WIDTH-1:0] tag;
  } sb_entry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: write-back bypass over the stored word, with r0 and reset gating.
module regfile_bypass_mux
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned INDEX_WIDTH     = 5
) (
  input  logic                                 rst_n_i,
  input  logic [INDEX_WIDTH-1:0]               rd_idx_i,
  input  logic [NUM_WRITE_PORTS-1:0]           wr_en_i,
  input  logic [NUM_WRITE_PORTS*INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0] wr_data_i,
  input  logic [WORD_SIZE-1:0]                 st_data_i,
  input  logic                                 st_busy_i,
  input  logic [TAG_WIDTH-1:0]                 st_tag_i,
  output logic [WORD_SIZE-1:0]                 rd_data_o,
  output logic                                 rd_busy_o,
  output logic [TAG_WIDTH-1:0]                 rd_tag_o
);

  always_comb begin
    rd_data_o = st_data_i;
    rd_busy_o = st_busy_i;
    rd_tag_o  = st_busy_i ? st_tag_i : '0;
    // Ascending scan so the highest-numbered matching port is the one that sticks.
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en_i[p] && wr_idx_i[p*INDEX_WIDTH +: INDEX_WIDTH] == rd_idx_i)
        rd_data_o = wr_data_i[p*WORD_SIZE +: WORD_SIZE];
    end
    if (!rst_n_i || rd_idx_i == INDEX_WIDTH'(ZERO_REG)) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
      rd_tag_o  = '0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-back bypass and a busy/tag scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned NUM_READ_PORTS  = 2,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned TAG_WIDTH       = SB_TAG_WIDTH,
  parameter int unsigned INDEX_WIDTH     = idx_width(NUM_REGS),
  parameter int unsigned COUNT_WIDTH     = cnt_width(NUM_REGS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_WRITE_PORTS-1:0]             write_enable,
  input  logic [NUM_WRITE_PORTS*INDEX_WIDTH-1:0] write_idx,
  input  logic [NUM_WRITE_PORTS*WORD_SIZE-1:0]   write_data,
  input  logic [NUM_WRITE_PORTS*TAG_WIDTH-1:0]   write_tag,
  input  logic                                   reserve_enable,
  input  logic [INDEX_WIDTH-1:0]                 reserve_idx,
  input  logic [TAG_WIDTH-1:0]                   reserve_tag,
  input  logic [NUM_READ_PORTS*INDEX_WIDTH-1:0]  read_idx,
  output logic [NUM_READ_PORTS*WORD_SIZE-1:0]    read_data,
  output logic [NUM_READ_PORTS-1:0]              read_busy,
  output logic [NUM_READ_PORTS*TAG_WIDTH-1:0]    read_tag,
  output logic [COUNT_WIDTH-1:0]                 busy_count
);

  typedef struct packed {
    logic                 busy;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  logic [WORD_SIZE-1:0]   data_q [NUM_REGS];
  logic [WORD_SIZE-1:0]   data_d [NUM_REGS];
  entry_t                 sb_q   [NUM_REGS];
  entry_t                 sb_wb  [NUM_REGS];  // after write-back clears, before reserves
  entry_t                 sb_d   [NUM_REGS];
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    logic                 hit;
    logic [TAG_WIDTH-1:0] hit_tag;
    hit     = 1'b0;
    hit_tag = '0;
    cnt_d   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      data_d[i] = data_q[i];
      sb_wb[i]  = sb_q[i];
      sb_d[i]   = sb_q[i];
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      hit     = 1'b0;
      hit_tag = '0;
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (write_enable[p] && write_idx[p*INDEX_WIDTH +: INDEX_WIDTH] == INDEX_WIDTH'(i)) begin
          hit       = 1'b1;
          hit_tag   = write_tag[p*TAG_WIDTH +: TAG_WIDTH];
          data_d[i] = write_data[p*WORD_SIZE +: WORD_SIZE];
        end
      end
      // A stale producer's write lands in storage but leaves ownership with the newer one.
      if (hit && sb_q[i].busy && sb_q[i].tag == hit_tag)
        sb_wb[i] = '0;
      sb_d[i] = sb_wb[i];
      if (reserve_enable && reserve_idx == INDEX_WIDTH'(i))
        sb_d[i] = '{busy: 1'b1, tag: reserve_tag};
    end
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + COUNT_WIDTH'(sb_d[i].busy);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        sb_q[i]   <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= data_d[i];
        sb_q[i]   <= sb_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  assign busy_count = cnt_q;

  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    logic [INDEX_WIDTH-1:0] idx;
    assign idx = read_idx[r*INDEX_WIDTH +: INDEX_WIDTH];

    regfile_bypass_mux #(
      .WORD_SIZE      (WORD_SIZE),
      .NUM_WRITE_PORTS(NUM_WRITE_PORTS),
      .TAG_WIDTH      (TAG_WIDTH),
      .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_mux (
      .rst_n_i  (reset),
      .rd_idx_i (idx),
      .wr_en_i  (write_enable),
      .wr_idx_i (write_idx),
      .wr_data_i(write_data),
      .st_data_i(data_q[idx]),
      .st_busy_i(sb_wb[idx].busy),
      .st_tag_i (sb_wb[idx].tag),
      .rd_data_o(read_data[r*WORD_SIZE +: WORD_SIZE]),
      .rd_busy_o(read_busy[r]),
      .rd_tag_o (read_tag[r*TAG_WIDTH +: TAG_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a per-register array model predicts every cycle's read ports and busy_count.
module tb_regfile_scoreboard;
  localparam int W = 32, NR = 32, RP = 2, WP = 2, TW = 4, IW = 5, CW = 6;

  logic              clk, reset;
  logic [WP-1:0]     write_enable;
  logic [WP*IW-1:0]  write_idx;
  logic [WP*W-1:0]   write_data;
  logic [WP*TW-1:0]  write_tag;
  logic              reserve_enable;
  logic [IW-1:0]     reserve_idx;
  logic [TW-1:0]     reserve_tag;
  logic [RP*IW-1:0]  read_idx;
  logic [RP*W-1:0]   read_data;
  logic [RP-1:0]     read_busy;
  logic [RP*TW-1:0]  read_tag;
  logic [CW-1:0]     busy_count;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .write_idx(write_idx),
    .write_data(write_data), .write_tag(write_tag),
    .reserve_enable(reserve_enable), .reserve_idx(reserve_idx), .reserve_tag(reserve_tag),
    .read_idx(read_idx), .read_data(read_data), .read_busy(read_busy),
    .read_tag(read_tag), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RP*W-1:0]  data;
    logic [RP-1:0]    busy;
    logic [RP*TW-1:0] tag;
    logic [CW-1:0]    cnt;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0, n_bad = 0;

  // Architectural model: contents, busy flag and owning tag per register.
  logic [W-1:0]  mdata [NR];
  bit            mbusy [NR];
  logic [TW-1:0] mtag  [NR];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int last_writer(input int idx);
    int lw = -1;
    for (int p = 0; p < WP; p++)
      if (write_enable[p] && int'(write_idx[p*IW +: IW]) == idx) lw = p;
    return lw;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic eval();
    exp_t e;
    e.data = '0; e.busy = '0; e.tag = '0;
    e.cnt  = CW'(model_count());
    for (int r = 0; r < RP; r++) begin
      int idx, lw;
      bit b;
      idx = int'(read_idx[r*IW +: IW]);
      if (reset && idx != 0) begin
        lw = last_writer(idx);
        e.data[r*W +: W] = (lw >= 0) ? write_data[lw*W +: W] : mdata[idx];
        b = mbusy[idx] && !(lw >= 0 && write_tag[lw*TW +: TW] == mtag[idx]);
        e.busy[r] = b;
        e.tag[r*TW +: TW] = b ? mtag[idx] : '0;
      end
    end
    expq.push_back(e);
  endtask

  task automatic commit();
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        mdata[i] = '0; mbusy[i] = 0; mtag[i] = '0;
      end
    end else begin
      for (int i = 1; i < NR; i++) begin
        int lw;
        lw = last_writer(i);
        if (lw >= 0) begin
          mdata[i] = write_data[lw*W +: W];
          if (mbusy[i] && mtag[i] == write_tag[lw*TW +: TW]) mbusy[i] = 0;
        end
      end
      if (reserve_enable && reserve_idx != 0) begin
        mbusy[reserve_idx] = 1;
        mtag[reserve_idx]  = reserve_tag;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval();
    @(negedge clk);
    commit();
  endtask

  task automatic clr();
    write_enable = '0; write_idx = '0; write_data = '0; write_tag = '0;
    reserve_enable = 0; reserve_idx = '0; reserve_tag = '0; read_idx = '0;
  endtask

  task automatic wr(input int p, input int idx, input logic [W-1:0] d, input int tag);
    write_enable[p] = 1'b1;
    write_idx[p*IW +: IW] = IW'(idx);
    write_data[p*W +: W]  = d;
    write_tag[p*TW +: TW] = TW'(tag);
  endtask

  task automatic res(input int idx, input int tag);
    reserve_enable = 1'b1; reserve_idx = IW'(idx); reserve_tag = TW'(tag);
  endtask

  task automatic setrd(input int r, input int idx);
    read_idx[r*IW +: IW] = IW'(idx);
  endtask

  function automatic logic [W-1:0] rd(input int r);
    return read_data[r*W +: W];
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("sb_read_data", 128'(read_data), 128'(e.data));
      chk("sb_read_busy", 128'(read_busy), 128'(e.busy));
      chk("sb_read_tag",  128'(read_tag),  128'(e.tag));
      chk("sb_busy_count", 128'(busy_count), 128'(e.cnt));
    end
  end

  initial begin
    clk = 0;
    for (int i = 0; i < NR; i++) begin
      mdata[i] = '0; mbusy[i] = 0; mtag[i] = '0;
    end
    clr(); reset = 0;
    @(posedge clk); #1;

    // Reset cycle with a write that must be dropped
    clr(); wr(0, 5, 32'h1234_5678, 0); setrd(0, 5);
    eval(); @(negedge clk); chk("rst_gated_read", 128'(rd(0)), 0); commit();
    reset = 1; clr(); setrd(0, 5);
    eval(); @(negedge clk);
    chk("rst_r5_data", 128'(rd(0)), 0);
    chk("rst_r5_busy", 128'(read_busy[0]), 0);
    chk("rst_count", 128'(busy_count), 0);
    commit();

    // Bypass then storage
    clr(); wr(0, 3, 32'hDEAD_BEEF, 0); setrd(0, 3);
    eval(); @(negedge clk); chk("bypass_r3", 128'(rd(0)), 128'(32'hDEAD_BEEF)); commit();
    clr(); setrd(0, 3);
    eval(); @(negedge clk); chk("stored_r3", 128'(rd(0)), 128'(32'hDEAD_BEEF)); commit();

    // Reserve, stale write, matching write
    clr(); res(7, 2); step();
    clr(); setrd(0, 7);
    eval(); @(negedge clk);
    chk("r7_busy", 128'(read_busy[0]), 1);
    chk("r7_tag", 128'(read_tag[TW-1:0]), 2);
    chk("r7_count", 128'(busy_count), 1);
    commit();
    clr(); wr(0, 7, 32'h11, 1); setrd(0, 7);
    eval(); @(negedge clk);
    chk("r7_stale_data", 128'(rd(0)), 128'(32'h11));
    chk("r7_stale_busy", 128'(read_busy[0]), 1);
    commit();
    clr(); wr(1, 7, 32'h77, 2); setrd(1, 7);
    eval(); @(negedge clk); chk("r7_clear_same_cycle", 128'(read_busy[1]), 0); commit();
    clr();
    eval(); @(negedge clk); chk("r7_count_after", 128'(busy_count), 0); commit();

    // r0 is immutable
    clr(); wr(0, 0, 32'hFFFF, 0); res(0, 5); setrd(0, 0);
    eval(); @(negedge clk);
    chk("r0_data", 128'(rd(0)), 0);
    chk("r0_busy", 128'(read_busy[0]), 0);
    commit();
    clr(); setrd(1, 0);
    eval(); @(negedge clk);
    chk("r0_data_next", 128'(read_data[2*W-1:W]), 0);
    chk("r0_count", 128'(busy_count), 0);
    commit();

    // Two ports on one index: higher port wins
    clr(); wr(0, 9, 32'hAAAA, 0); wr(1, 9, 32'h5555, 0); setrd(0, 9);
    eval(); @(negedge clk); chk("r9_bypass", 128'(rd(0)), 128'(32'h5555)); commit();
    clr(); setrd(0, 9);
    eval(); @(negedge clk); chk("r9_stored", 128'(rd(0)), 128'(32'h5555)); commit();

    // Reserve beats a matching write in the same cycle
    clr(); res(4, 3); step();
    clr(); res(4, 6); wr(1, 4, 32'h44, 3); setrd(0, 4);
    eval(); @(negedge clk); chk("r4_count_before", 128'(busy_count), 1); commit();
    clr(); setrd(0, 4);
    eval(); @(negedge clk);
    chk("r4_data", 128'(rd(0)), 128'(32'h44));
    chk("r4_busy", 128'(read_busy[0]), 1);
    chk("r4_tag", 128'(read_tag[TW-1:0]), 6);
    chk("r4_count", 128'(busy_count), 1);
    commit();

    // Random traffic over a narrow index/tag space to force collisions
    repeat (600) begin
      clr();
      reset = ($urandom_range(0, 59) != 0);
      for (int p = 0; p < WP; p++)
        if ($urandom_range(0, 2) != 0)
          wr(p, $urandom_range(0, 15), $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) res($urandom_range(0, 15), $urandom_range(0, 3));
      for (int r = 0; r < RP; r++) setrd(r, $urandom_range(0, 15));
      step();
    end

    reset = 1; clr();
    repeat (2) step();
    if (expq.size() != 0) chk("queue_drained", 128'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
